mem_stage_sram_ctrl: RTL and testbench
======================================

// Module: mem_stage_sram_ctrl
// PURPOSE
//  - MEM stage of the ARM pipeline; sits directly downstream of the EXE/MEM pipeline register.
//  - Runs data-memory loads and stores (LDR/STR) against an external single-port SRAM with fixed wait states.
//  - Drops ready while an access is in flight; the hazard/freeze logic stalls every upstream stage.
//  - Passes WB controls, ALU result and Dest on to the MEM/WB register.
// PARAMETERS
//  DATA_BASE    1024  byte address of data-memory word 0; subtracted from ALU_result_in
//  ADDR_W       16    SRAM word-address width
//  WAIT_CYCLES  4     SRAM access cycles, >=1; elaboration error if 0
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  WB_EN_in        in   1       write-back enable from EXE/MEM reg
//  MEM_R_EN_in     in   1       load request
//  MEM_W_EN_in     in   1       store request
//  ALU_result_in   in   32      effective byte address / ALU value
//  Val_Rm_in       in   32      store data
//  Dest_in         in   4       destination register
//  WB_EN           out  1       = WB_EN_in (combinational)
//  MEM_R_EN        out  1       = MEM_R_EN_in (combinational)
//  ALU_result      out  32      = ALU_result_in (combinational)
//  Dest            out  4       = Dest_in (combinational)
//  Mem_read_value  out  32      registered load data
//  ready           out  1       0 = freeze the pipeline
//  sram_addr       out  ADDR_W  registered word address
//  sram_wdata      out  32      registered store data
//  sram_rdata      in   32      SRAM read data, valid in the last access cycle
//  sram_ce_n       out  1       chip enable, active-low
//  sram_we_n       out  1       write enable, active-low
//  sram_oe_n       out  1       output enable, active-low
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE, cnt=0, Mem_read_value=0, sram_addr=0, sram_wdata=0.
//    - sram_ce_n=sram_we_n=sram_oe_n=1; ready=1.
//    - Passthrough outputs have no state and follow their inputs.
//  - Request: req = MEM_R_EN_in | MEM_W_EN_in.
//  - Word address: sram_addr <= (ALU_result_in - DATA_BASE)[ADDR_W+1:2].
//    - Subtraction is 32-bit modulo; bits [1:0] are ignored.
//  - FSM IDLE -> BUSY -> DONE -> IDLE:
//    - IDLE:
//      - ready = ~req (combinational).
//      - On a req edge: latch sram_addr and sram_wdata=Val_Rm_in; ce_n<=0; cnt<=0.
//      - Store: we_n<=0, oe_n<=1. Load: we_n<=1, oe_n<=0.
//      - Go to BUSY.
//    - BUSY:
//      - ready=0; cnt++ each edge.
//      - At cnt==WAIT_CYCLES-1: if load, Mem_read_value<=sram_rdata.
//      - Same edge: ce_n/we_n/oe_n<=1 and go to DONE.
//    - DONE:
//      - ready=1 for exactly one cycle so the pipeline advances.
//      - Unconditionally goes to IDLE; the new instruction is evaluated there.
//  - Latency: access holds ready=0 for 1+WAIT_CYCLES cycles plus 1 DONE cycle. A non-memory instruction adds 0 cycles.
//  - Upstream holds all *_in stable while ready=0. The block re-samples nothing during BUSY.
//  - MEM_R_EN_in & MEM_W_EN_in both set: treated as a store; Mem_read_value unchanged.
//  - A store never modifies Mem_read_value.
//  - Back-to-back memory ops: DONE->IDLE->new access; ready pattern ...1(DONE),0(IDLE),0...
//  - rst_n low mid-access: SRAM strobes deassert immediately (async). Access abandoned, FSM to IDLE, SRAM contents undefined.
// CONFIGURATION
//  - MEM_RANGE_CHECK_EN defined:
//    - Adds output addr_err (1 bit, reset 0).
//    - In IDLE, req with (ALU_result_in - DATA_BASE) >= 4*2^ADDR_W (unsigned) asserts addr_err combinationally.
//    - ready stays 1 and no SRAM strobe asserts.
//    - A load sets Mem_read_value<=0 on that edge; a store is dropped.
//  - MEM_RANGE_CHECK_EN undefined: no addr_err port; address silently wraps modulo 2^ADDR_W words.
// TESTING
//  - Reset: hold rst_n=0, any inputs -> ready=1, strobes=1, Mem_read_value=0; release -> IDLE.
//  - STR: ALU_result_in=1032, Val_Rm_in=0xDEADBEEF, WAIT_CYCLES=4.
//    - sram_addr=2, we_n=0 for 4 cycles.
//    - ready low 5 cycles, high 1 cycle in DONE.
//  - LDR from 1032 after the STR -> Mem_read_value=0xDEADBEEF in DONE. oe_n=0, we_n=1 during BUSY.
//  - ADD (no req) between loads -> ready stays 1, no strobe, passthroughs equal inputs same cycle.
//  - LDR then STR back-to-back -> second access starts in the cycle after DONE; ready 0 again.
//  - rst_n pulsed low in BUSY cycle 2 -> ce_n=1 immediately, ready=1, IDLE after release.
//  - MEM_RANGE_CHECK_EN: LDR at 1024+4*2^16 -> addr_err=1, ready=1, Mem_read_value=0, no strobe.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// SRAM bus between the MEM-stage controller and an external single-port SRAM.
//   master : controller side, drives address, write data and the active-low strobes
//   slave  : SRAM side, returns read data
// Ports carried:
//   sram_addr  [ADDR_W] word address      sram_wdata [32] store data
//   sram_rdata [32]     load data         sram_ce_n / sram_we_n / sram_oe_n  strobes
interface mem_stage_sram_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  modport master (
    output sram_addr, sram_wdata, sram_ce_n, sram_we_n, sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_wdata, sram_ce_n, sram_we_n, sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage of the ARM pipeline. Runs LDR/STR against a single-port SRAM with a fixed
// number of access cycles and drops ready while an access is in flight so the
// upstream stages freeze. WB controls, ALU result and Dest pass straight through.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   WB_EN_in .. Dest_in        EXE/MEM register outputs
//   WB_EN, MEM_R_EN,
//   ALU_result, Dest           combinational passthroughs to MEM/WB
//   Mem_read_value             registered load data
//   ready                      0 = freeze the pipeline
//   sram                       SRAM bus (master side)
//   addr_err                   only with MEM_RANGE_CHECK_EN: out-of-range access in IDLE
// Optional feature macro: MEM_RANGE_CHECK_EN (address range check instead of wrap).
module mem_stage_sram_ctrl #(
  parameter int unsigned DATA_BASE   = 1024,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] Val_Rm_in,
  input  logic [3:0]  Dest_in,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_result,
  output logic [3:0]  Dest,
  output logic [31:0] Mem_read_value,
  output logic        ready,
`ifdef MEM_RANGE_CHECK_EN
  output logic        addr_err,
`endif
  mem_stage_sram_ctrl_if.master sram
);

  if (WAIT_CYCLES == 0) begin : gen_bad_wait
    $error("mem_stage_sram_ctrl: WAIT_CYCLES must be >= 1");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : gen_bad_addr_w
    $error("mem_stage_sram_ctrl: ADDR_W must be in 1..29");
  end

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              load_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ce_n_q, we_n_q, oe_n_q;

  logic        req;
  logic        is_store;
  logic [31:0] offset;
  logic        range_bad;
  logic        unused_offset;

  assign WB_EN      = WB_EN_in;
  assign MEM_R_EN   = MEM_R_EN_in;
  assign ALU_result = ALU_result_in;
  assign Dest       = Dest_in;

  assign req      = MEM_R_EN_in | MEM_W_EN_in;
  // Both enables set counts as a store.
  assign is_store = MEM_W_EN_in;
  assign offset   = ALU_result_in - 32'(DATA_BASE);

`ifdef MEM_RANGE_CHECK_EN
  assign range_bad     = |offset[31:ADDR_W+2];
  assign unused_offset = ^offset[1:0];
  assign addr_err      = rst_n & (state_q == IDLE) & req & range_bad;
`else
  // Upper offset bits are dropped: the address wraps modulo 2^ADDR_W words.
  assign range_bad     = 1'b0;
  assign unused_offset = ^{offset[31:ADDR_W+2], offset[1:0]};
`endif

  always_comb begin
    ready = 1'b1;
    if (rst_n) begin
      case (state_q)
        IDLE:    ready = ~req | range_bad;
        BUSY:    ready = 1'b0;
        default: ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !range_bad) begin
            addr_q  <= offset[ADDR_W+1:2];
            wdata_q <= Val_Rm_in;
            ce_n_q  <= 1'b0;
            we_n_q  <= ~is_store;
            oe_n_q  <= is_store;
            load_q  <= ~is_store;
            cnt_q   <= '0;
            state_q <= BUSY;
          end else if (req && !is_store) begin
            // Out-of-range load returns zero without touching the SRAM.
            rdata_q <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            if (load_q) rdata_q <= sram.sram_rdata;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        // One ready cycle lets the pipeline advance before the next instruction is seen.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Mem_read_value  = rdata_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;
  assign sram.sram_ce_n  = ce_n_q;
  assign sram.sram_we_n  = we_n_q;
  assign sram.sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural SRAM and a scoreboard of
// expected Mem_read_value results, popped when each access reaches its DONE cycle.
module tb_mem_stage_sram_ctrl;
  localparam int unsigned WAIT = 4;
  localparam int unsigned AW   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_result_in, Val_Rm_in;
  logic [3:0]  Dest_in;
  logic        WB_EN, MEM_R_EN;
  logic [31:0] ALU_result;
  logic [3:0]  Dest;
  logic [31:0] Mem_read_value;
  logic        ready;
`ifdef MEM_RANGE_CHECK_EN
  logic        addr_err;
`endif

  mem_stage_sram_ctrl_if #(.ADDR_W(AW)) sif ();

  mem_stage_sram_ctrl #(
    .DATA_BASE  (1024),
    .ADDR_W     (AW),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .WB_EN_in      (WB_EN_in),
    .MEM_R_EN_in   (MEM_R_EN_in),
    .MEM_W_EN_in   (MEM_W_EN_in),
    .ALU_result_in (ALU_result_in),
    .Val_Rm_in     (Val_Rm_in),
    .Dest_in       (Dest_in),
    .WB_EN         (WB_EN),
    .MEM_R_EN      (MEM_R_EN),
    .ALU_result    (ALU_result),
    .Dest          (Dest),
    .Mem_read_value(Mem_read_value),
    .ready         (ready),
`ifdef MEM_RANGE_CHECK_EN
    .addr_err      (addr_err),
`endif
    .sram          (sif.master)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM.
  logic [31:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sif.sram_ce_n && !sif.sram_we_n) sram_mem[sif.sram_addr] <= sif.sram_wdata;
  end
  assign sif.sram_rdata = (!sif.sram_ce_n && !sif.sram_oe_n) ? sram_mem[sif.sram_addr] : 32'hx;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = 32'h0;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] alu);
    logic [31:0] off;
    off = alu - 32'd1024;
    return int'((off >> 2) & 32'h0000_FFFF);
  endfunction

  task automatic idle_inputs();
    WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_result_in = 32'h0; Val_Rm_in = 32'h0; Dest_in = 4'h0;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after DONE.
  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] val, input string tag);
    int n_low, n_ce, n_we, n_oe;
    logic [31:0] exp_v;
    WB_EN_in = rd & ~wr; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
    ALU_result_in = alu; Val_Rm_in = val; Dest_in = 4'd3;
    if (wr) ref_mem[word_of(alu)] = val;
    else last_rd = ref_mem[word_of(alu)];
    exp_q.push_back(last_rd);
    #1;
    n_low = 0; n_ce = 0; n_we = 0; n_oe = 0;
    while (ready === 1'b0 && n_low < 20) begin
      n_low++;
      @(negedge clk); #1;
      if (ready === 1'b0) begin
        if (sif.sram_ce_n === 1'b0) n_ce++;
        if (sif.sram_we_n === 1'b0) n_we++;
        if (sif.sram_oe_n === 1'b0) n_oe++;
        if (n_low == 1) begin
          check({tag, "_addr"}, 32'(sif.sram_addr), 32'(word_of(alu)));
          if (wr) check({tag, "_wdata"}, sif.sram_wdata, val);
        end
      end
    end
    check({tag, "_ready_low"}, n_low, 1 + WAIT);
    check({tag, "_done_ready"}, 32'(ready), 32'd1);
    check({tag, "_ce_cycles"}, n_ce, WAIT);
    check({tag, "_we_cycles"}, n_we, wr ? WAIT : 0);
    check({tag, "_oe_cycles"}, n_oe, wr ? 0 : WAIT);
    check({tag, "_done_ce_n"}, 32'(sif.sram_ce_n), 32'd1);
    exp_v = exp_q.pop_front();
    check({tag, "_read_value"}, Mem_read_value, exp_v);
    @(negedge clk);
  endtask

  task automatic nomem(input string tag);
    WB_EN_in = 1'b1; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_result_in = 32'h0BAD_F00D; Val_Rm_in = 32'h1111_2222; Dest_in = 4'd9;
    #1;
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_wb_en"}, 32'(WB_EN), 32'd1);
    check({tag, "_mem_r_en"}, 32'(MEM_R_EN), 32'd0);
    check({tag, "_alu"}, ALU_result, 32'h0BAD_F00D);
    check({tag, "_dest"}, 32'(Dest), 32'd9);
    @(negedge clk); #1;
    check({tag, "_ready2"}, 32'(ready), 32'd1);
    check({tag, "_ce_n"}, 32'(sif.sram_ce_n), 32'd1);
    check({tag, "_read_value"}, Mem_read_value, last_rd);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b1;
    ALU_result_in = 32'hFFFF_FFF0; Val_Rm_in = 32'h5555_AAAA; Dest_in = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ce_n", 32'(sif.sram_ce_n), 32'd1);
    check("rst_we_n", 32'(sif.sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sif.sram_oe_n), 32'd1);
    check("rst_read_value", Mem_read_value, 32'h0);
    check("rst_addr", 32'(sif.sram_addr), 32'h0);
    check("rst_wdata", sif.sram_wdata, 32'h0);
    check("rst_passthru_alu", ALU_result, 32'hFFFF_FFF0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    check("post_rst_ready", 32'(ready), 32'd1);
    @(negedge clk); #1;
    check("post_rst_ce_n", 32'(sif.sram_ce_n), 32'd1);
    @(negedge clk);

    mem_op(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, "str1");
    nomem("add1");
    mem_op(1'b1, 1'b0, 32'd1032, 32'h0, "ldr1");
    nomem("add2");
    mem_op(1'b1, 1'b0, 32'd1032, 32'h0, "ldr2");
    mem_op(1'b0, 1'b1, 32'd1036, 32'hCAFE_F00D, "str2");
    mem_op(1'b1, 1'b0, 32'd1036, 32'h0, "ldr3");
    mem_op(1'b1, 1'b1, 32'd1044, 32'hA5A5_A5A5, "rw_both");
    mem_op(1'b1, 1'b0, 32'd1044, 32'h0, "ldr4");

`ifdef MEM_RANGE_CHECK_EN
    WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b0;
    ALU_result_in = 32'd1024 + 32'h0004_0000; Val_Rm_in = 32'h0; Dest_in = 4'd2;
    #1;
    check("range_addr_err", 32'(addr_err), 32'd1);
    check("range_ready", 32'(ready), 32'd1);
    @(negedge clk); #1;
    check("range_read_value", Mem_read_value, 32'h0);
    check("range_ce_n", 32'(sif.sram_ce_n), 32'd1);
    last_rd = 32'h0;
    idle_inputs();
    #1;
    check("range_addr_err_clr", 32'(addr_err), 32'd0);
    @(negedge clk);
`else
    mem_op(1'b1, 1'b0, 32'd1024 + 32'h0004_0008, 32'h0, "wrap");
`endif

    // Reset pulsed during the second BUSY cycle of a load.
    WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b0;
    ALU_result_in = 32'd1032; Val_Rm_in = 32'h0; Dest_in = 4'd4;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_busy_ce_n", 32'(sif.sram_ce_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_ce_n", 32'(sif.sram_ce_n), 32'd1);
    check("midrst_oe_n", 32'(sif.sram_oe_n), 32'd1);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_read_value", Mem_read_value, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    check("midrst_idle_ready", 32'(ready), 32'd1);
    @(negedge clk); #1;
    check("midrst_idle_ce_n", 32'(sif.sram_ce_n), 32'd1);
    @(negedge clk);
    mem_op(1'b1, 1'b0, 32'd1036, 32'h0, "ldr_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
